// File: rtl/wino_pkg.sv
// Shared constants for the Winograd tile loader.
// Tile geometry, FSM encoding and operand byte lanes.
package wino_pkg;

  localparam int WINO_NUM_WORDS = 14;
  localparam int WINO_DATA_W    = 32;
  localparam int WINO_CNT_W     = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_FULL = 2'd2;

  localparam int LANE_HI = 8;
  localparam int LANE_LO = 0;

endpackage

// File: rtl/wino_tile_loader_if.sv
// Word stream in, framed tile out.
// The master side feeds words and drains tiles.
interface wino_tile_loader_if
  import wino_pkg::*;
#(
  parameter int NUM_WORDS  = WINO_NUM_WORDS,
  parameter int DATA_WIDTH = WINO_DATA_W,
  parameter int CNT_W      = WINO_CNT_W
);

  logic                            clear;
  logic                            in_valid;
  logic [DATA_WIDTH-1:0]           in_data;
  logic                            in_last;
  logic                            in_ready;
  logic                            tile_valid;
  logic                            tile_ready;
  logic [NUM_WORDS*DATA_WIDTH-1:0] tile_data;
  logic [CNT_W-1:0]                fill_count;
  logic                            err_frame;

  modport master (
    output clear, in_valid, in_data, in_last, tile_ready,
    input  in_ready, tile_valid, tile_data, fill_count, err_frame
  );

  modport slave (
    input  clear, in_valid, in_data, in_last, tile_ready,
    output in_ready, tile_valid, tile_data, fill_count, err_frame
  );

endinterface

// File: rtl/wino_word_bank.sv
// Tile register file: one write port, flattened read-out.
// Word k sits at bits [k*DATA_WIDTH +: DATA_WIDTH].
module wino_word_bank
  import wino_pkg::*;
#(
  parameter int NUM_WORDS  = WINO_NUM_WORDS,
  parameter int DATA_WIDTH = WINO_DATA_W,
  parameter int IDX_W      = WINO_CNT_W
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            we_i,
  input  logic [IDX_W-1:0]                idx_i,
  input  logic [DATA_WIDTH-1:0]           wdata_i,
  output logic [NUM_WORDS*DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [NUM_WORDS];

  // Store accepted words; reset clears every slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
  end

  for (genvar k = 0; k < NUM_WORDS; k++) begin : g_flat
    assign rdata_o[k*DATA_WIDTH +: DATA_WIDTH] = mem_q[k];
  end

endmodule

// File: rtl/wino_tile_loader.sv
// Frames a word stream into tiles for the Winograd unit.
// Counts words, flags short/long frames, holds full tiles.
module wino_tile_loader
  import wino_pkg::*;
#(
  parameter int NUM_WORDS  = WINO_NUM_WORDS,
  parameter int DATA_WIDTH = WINO_DATA_W,
  parameter int CNT_W      = WINO_CNT_W
) (
  input logic                clk,
  input logic                rst,
  wino_tile_loader_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_WORDS);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic             full;
  logic             acc;
  logic [CNT_W-1:0] pos;
  logic             at_last;
  logic             wr_en;

  assign full = (state_q == ST_FULL);

  // A full tile leaving this cycle frees the bank for a new word 0.
  assign bus.in_ready = rst & (~full | bus.tile_ready);

  assign acc     = bus.in_valid & bus.in_ready & ~bus.clear;
  assign pos     = full ? '0 : cnt_q;
  assign at_last = (pos == LAST_IDX);
  assign wr_en   = acc & (at_last == bus.in_last);

  assign bus.tile_valid = full;
  assign bus.fill_count = cnt_q;
  assign bus.err_frame  = err_q;

  wino_word_bank #(
    .NUM_WORDS  (NUM_WORDS),
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (CNT_W)
  ) u_bank (
    .clk     (clk),
    .rst     (rst),
    .we_i    (wr_en),
    .idx_i   (pos),
    .wdata_i (bus.in_data),
    .rdata_o (bus.tile_data)
  );

  // Next state: clear wins, then drain, then classify the accepted word.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (bus.clear) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      err_d   = 1'b0;
    end else begin
      if (full & bus.tile_ready) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      if (acc) begin
        unique case (1'b1)
          (at_last & bus.in_last): begin
            state_d = ST_FULL;
            cnt_d   = FULL_CNT;
          end
          (at_last ^ bus.in_last): begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            err_d   = 1'b1;
          end
          default: begin
            state_d = ST_FILL;
            cnt_d   = pos + 1'b1;
          end
        endcase
      end
    end
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule
